// File: rtl/binary_to_bcd.sv
// 5-bit unsigned binary to two-digit packed BCD converter.
// Combinational shift-and-add-3 conversion feeding a single output register.
module binary_to_bcd (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] binary_input,
  output logic [7:0] bcd_output
);

  localparam int unsigned BIN_W = 5;
  localparam int unsigned BCD_W = 8;
  localparam int unsigned SR_W  = BIN_W + BCD_W;

  logic [SR_W-1:0]  shift_reg;
  logic [BCD_W-1:0] bcd_next_c;

  // Double dabble: bump any digit >= 5 by 3 before each left shift.
  always_comb begin
    shift_reg = {BCD_W'(0), binary_input};
    for (int i = 0; i < int'(BIN_W); i++) begin
      if (shift_reg[BIN_W+3:BIN_W] >= 4'd5) begin
        shift_reg[BIN_W+3:BIN_W] = shift_reg[BIN_W+3:BIN_W] + 4'd3;
      end
      if (shift_reg[BIN_W+7:BIN_W+4] >= 4'd5) begin
        shift_reg[BIN_W+7:BIN_W+4] = shift_reg[BIN_W+7:BIN_W+4] + 4'd3;
      end
      shift_reg = shift_reg << 1;
    end
    bcd_next_c = shift_reg[SR_W-1:BIN_W];
  end

  // Output register; reset clears any pending conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_output <= BCD_W'(0);
    end else begin
      bcd_output <= bcd_next_c;
    end
  end

endmodule

// File: tb/tb_binary_to_bcd.sv
// Self-checking bench for binary_to_bcd: arithmetic reference model plus
// directed literal checks, exhaustive sweep and randomized stimulus with glitches.
module tb_binary_to_bcd;

  logic       clk;
  logic       rst;
  logic [4:0] binary_input;
  logic [7:0] bcd_output;

  int tests = 0;
  int fails = 0;

  logic       exp_valid = 1'b0;
  logic [7:0] exp_bcd   = 8'h00;

  binary_to_bcd dut (
    .clk          (clk),
    .rst          (rst),
    .binary_input (binary_input),
    .bcd_output   (bcd_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 8'h%h expected 8'h%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decimal digits by plain division, one-cycle latency.
  always @(posedge clk) begin
    exp_valid <= exp_valid | rst;
    if (rst) exp_bcd <= 8'h00;
    else     exp_bcd <= 8'((32'(binary_input) / 10) * 16 + (32'(binary_input) % 10));
  end

  // Compare process: model match plus digit-range / top-bit legality.
  always @(negedge clk) begin
    if (exp_valid) begin
      check("model", bcd_output, exp_bcd);
      tests++;
      if (bcd_output[7:6] !== 2'b00 || bcd_output[7:4] > 4'd9 || bcd_output[3:0] > 4'd9) begin
        fails++;
        $display("FAIL legal_digits: got 8'h%h required nibbles<=9 and [7:6]=0 at %0t",
                 bcd_output, $time);
      end
    end
  end

  // Apply inputs just after a falling edge; return at the next falling edge.
  task automatic step(input logic r, input logic [4:0] v);
    rst          = r;
    binary_input = v;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] v;
    rst          = 1'b1;
    binary_input = 5'b10101;
    @(negedge clk);
    check("reset_cycle1", bcd_output, 8'h00);
    step(1'b1, 5'b10101);
    check("reset_cycle2", bcd_output, 8'h00);
    step(1'b0, 5'b10101);
    check("release_21", bcd_output, 8'h21);

    step(1'b0, 5'd0);
    check("zero", bcd_output, 8'h00);
    step(1'b0, 5'd31);
    check("max_31", bcd_output, 8'h31);

    // Exhaustive sweep with a one-cycle reset while input is 17.
    for (int i = 0; i < 32; i++) begin
      v = 5'(i);
      if (i == 17) begin
        step(1'b1, v);
        check("mid_reset_17", bcd_output, 8'h00);
      end else begin
        step(1'b0, v);
        case (i)
          9:  check("sweep_9",  bcd_output, 8'h09);
          10: check("sweep_10", bcd_output, 8'h10);
          18: check("after_reset_18", bcd_output, 8'h18);
          19: check("sweep_19", bcd_output, 8'h19);
          20: check("sweep_20", bcd_output, 8'h20);
          29: check("sweep_29", bcd_output, 8'h29);
          30: check("sweep_30", bcd_output, 8'h30);
          default: ;
        endcase
      end
    end

    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'b11111);
      check("hold_31", bcd_output, 8'h31);
    end
    step(1'b0, 5'b00000);
    check("hold_then_0", bcd_output, 8'h00);

    // Random stream with mid-cycle glitches and occasional reset.
    for (int i = 0; i < 400; i++) begin
      rst          = ($urandom_range(15) == 0);
      binary_input = 5'($urandom);
      #1 binary_input = 5'($urandom);
      #1 binary_input = 5'($urandom);
      @(negedge clk);
    end

    rst = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
